// File: rtl/rf_writeback_arbiter_pkg.sv
// rf_writeback_arbiter_pkg
// Shared definitions for the register file writeback path: datapath and
// register-address widths, register index constants and the coprocessor
// result FIFO entry layout.
// No ports (package only).
package rf_writeback_arbiter_pkg;

  localparam int W_CPU    = 32;
  localparam int W_REG    = 5;
  localparam int NUM_REGS = 1 << W_REG;

  // $0 is hardwired to zero: writes to it are suppressed and it is never
  // marked busy.
  localparam logic [W_REG-1:0] REG_ZERO = '0;

  // One buffered coprocessor result: destination register and data.
  typedef struct packed {
    logic [W_REG-1:0] wa;
    logic [W_CPU-1:0] wd;
  } cq_entry_t;

endpackage

// File: rtl/rf_writeback_arbiter_fifo.sv
// wb_result_fifo
// Small synchronous FIFO holding coprocessor results until they win the
// register file write port. DEPTH must be a power of two (pointers wrap by
// natural overflow). Push while full and pop while empty are ignored.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (empties the FIFO)
//   push         enqueue push_data this cycle
//   push_data    entry to enqueue
//   pop          dequeue the head this cycle
//   pop_data     current head entry (valid when !empty)
//   full, empty  occupancy flags
//   count        current occupancy, 0..DEPTH
module wb_result_fifo
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  cq_entry_t push_data,
  input  logic      pop,
  output cq_entry_t pop_data,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);

  cq_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Storage is not reset: stale entries are unreachable once the pointers
  // and count are cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter
// Owns the single register file write port. Merges the fixed-latency
// pipeline writeback (never back-pressured) with variable-latency
// coprocessor results (valid/ready, buffered in wb_result_fifo), guards the
// FIFO against starvation, and keeps a busy-bit scoreboard of registers
// awaiting coprocessor results.
// Optional build macro: WB_BYPASS_EN adds byp1_*/byp2_* forwarding outputs.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pipe_wren/wa/wd          pipeline writeback request
//   pipe_stall               core must hold pipe_wren low this cycle
//   cp_issue, cp_issue_reg   coprocessor op issued; marks destination busy
//   cp_valid, cp_ready       coprocessor result handshake
//   cp_wa, cp_wd             coprocessor result destination and data
//   ra1, ra2                 hazard query addresses
//   busy1, busy2             scoreboard bits for ra1/ra2
//   rf_wren/wa/wd            registered register file write port
//   byp1/2_hit, byp1/2_data  forwarding of this edge's commit (WB_BYPASS_EN)
//   cq_count                 current FIFO occupancy
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int  CQ_DEPTH   = 4,
  parameter int  STARVE_MAX = 4,
  localparam int CNT_W      = $clog2(CQ_DEPTH) + 1,
  localparam int SW         = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_wren,
  input  logic [W_REG-1:0] pipe_wa,
  input  logic [W_CPU-1:0] pipe_wd,
  output logic             pipe_stall,
  input  logic             cp_issue,
  input  logic [W_REG-1:0] cp_issue_reg,
  input  logic             cp_valid,
  output logic             cp_ready,
  input  logic [W_REG-1:0] cp_wa,
  input  logic [W_CPU-1:0] cp_wd,
  input  logic [W_REG-1:0] ra1,
  input  logic [W_REG-1:0] ra2,
  output logic             busy1,
  output logic             busy2,
  output logic             rf_wren,
  output logic [W_REG-1:0] rf_wa,
  output logic [W_CPU-1:0] rf_wd,
`ifdef WB_BYPASS_EN
  output logic             byp1_hit,
  output logic             byp2_hit,
  output logic [W_CPU-1:0] byp1_data,
  output logic [W_CPU-1:0] byp2_data,
`endif
  output logic [CNT_W-1:0] cq_count
);

  cq_entry_t           cq_in;
  cq_entry_t           cq_head;
  logic                cq_full;
  logic                cq_empty;
  logic                cq_push;
  logic                pipe_req;
  logic                pipe_win;
  logic                fifo_win;
  logic [SW-1:0]       starve_cnt;
  logic [SW-1:0]       starve_inc;
  logic [SW-1:0]       starve_next;
  logic                starve_hit;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Results addressed to $0 complete the handshake but are never stored.
  assign cp_ready = !cq_full;
  assign cq_push  = cp_valid && !cq_full && (cp_wa != REG_ZERO);
  assign cq_in    = '{wa: cp_wa, wd: cp_wd};

  wb_result_fifo #(
    .DEPTH(CQ_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cq_push),
    .push_data(cq_in),
    .pop      (fifo_win),
    .pop_data (cq_head),
    .full     (cq_full),
    .empty    (cq_empty),
    .count    (cq_count)
  );

  assign pipe_req = pipe_wren && (pipe_wa != REG_ZERO);

  // During a forced-priority cycle the core has been told to stall, so
  // pipe_wren is ignored and the FIFO head takes the port.
  always_comb begin
    pipe_win = 1'b0;
    fifo_win = 1'b0;
    if (pipe_stall) begin
      fifo_win = !cq_empty;
    end else if (pipe_req) begin
      pipe_win = 1'b1;
    end else begin
      fifo_win = !cq_empty;
    end
  end

  // Count consecutive cycles where queued results lose to the pipeline.
  // Reaching the limit raises a one-cycle registered stall and restarts the
  // count; the stall cycle itself always pops, which keeps it at zero.
  always_comb begin
    starve_inc  = starve_cnt + 1'b1;
    starve_next = starve_cnt;
    starve_hit  = 1'b0;
    if (fifo_win || cq_empty) begin
      starve_next = '0;
    end else if (pipe_win) begin
      if (starve_inc == SW'(STARVE_MAX)) begin
        starve_hit  = 1'b1;
        starve_next = '0;
      end else begin
        starve_next = starve_inc;
      end
    end
  end

  // Clear for the popped result first, then apply the issue, so an issue
  // to the register being retired in the same cycle leaves it busy.
  always_comb begin
    busy_next = busy;
    if (fifo_win) begin
      busy_next[cq_head.wa] = 1'b0;
    end
    if (cp_issue && (cp_issue_reg != REG_ZERO)) begin
      busy_next[cp_issue_reg] = 1'b1;
    end
  end

  assign busy1 = (ra1 != REG_ZERO) && busy[ra1];
  assign busy2 = (ra2 != REG_ZERO) && busy[ra2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
      busy       <= '0;
    end else begin
      starve_cnt <= starve_next;
      pipe_stall <= starve_hit;
      busy       <= busy_next;
    end
  end

  // Register the winner onto the write port; address and data hold their
  // last value when nothing is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wren <= 1'b0;
      rf_wa   <= '0;
      rf_wd   <= '0;
    end else begin
      rf_wren <= pipe_win || fifo_win;
      if (pipe_win) begin
        rf_wa <= pipe_wa;
        rf_wd <= pipe_wd;
      end else if (fifo_win) begin
        rf_wa <= cq_head.wa;
        rf_wd <= cq_head.wd;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the value the register file commits at this edge to decode.
  assign byp1_hit  = rf_wren && (rf_wa == ra1) && (ra1 != REG_ZERO);
  assign byp2_hit  = rf_wren && (rf_wa == ra2) && (ra2 != REG_ZERO);
  assign byp1_data = rf_wd;
  assign byp2_data = rf_wd;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter
// Self-checking bench for rf_writeback_arbiter. Each vector carries the
// inputs for one cycle plus the outputs required after the following edge;
// vectors are queued as they are driven and popped when outputs are sampled.
module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wren;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        pipe_stall;
  logic        cp_issue;
  logic [4:0]  cp_issue_reg;
  logic        cp_valid;
  logic        cp_ready;
  logic [4:0]  cp_wa;
  logic [31:0] cp_wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        busy1;
  logic        busy2;
  logic        rf_wren;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
`ifdef WB_BYPASS_EN
  logic        byp1_hit;
  logic        byp2_hit;
  logic [31:0] byp1_data;
  logic [31:0] byp2_data;
`endif
  logic [2:0]  cq_count;

  always #5 clk = ~clk;

  rf_writeback_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_wren   (pipe_wren),
    .pipe_wa     (pipe_wa),
    .pipe_wd     (pipe_wd),
    .pipe_stall  (pipe_stall),
    .cp_issue    (cp_issue),
    .cp_issue_reg(cp_issue_reg),
    .cp_valid    (cp_valid),
    .cp_ready    (cp_ready),
    .cp_wa       (cp_wa),
    .cp_wd       (cp_wd),
    .ra1         (ra1),
    .ra2         (ra2),
    .busy1       (busy1),
    .busy2       (busy2),
    .rf_wren     (rf_wren),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
`ifdef WB_BYPASS_EN
    .byp1_hit    (byp1_hit),
    .byp2_hit    (byp2_hit),
    .byp1_data   (byp1_data),
    .byp2_data   (byp2_data),
`endif
    .cq_count    (cq_count)
  );

  typedef struct {
    logic        pw;
    logic [4:0]  pwa;
    logic [31:0] pwd;
    logic        ci;
    logic [4:0]  cir;
    logic        cv;
    logic [4:0]  cwa;
    logic [31:0] cwd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        ew;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic        eb1;
    logic        eb2;
    logic [2:0]  ec;
    logic        es;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[12];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(
    input logic pw, input logic [4:0] pwa, input logic [31:0] pwd,
    input logic ci, input logic [4:0] cir,
    input logic cv, input logic [4:0] cwa, input logic [31:0] cwd,
    input logic [4:0] a1, input logic [4:0] a2,
    input logic ew, input logic [4:0] ewa, input logic [31:0] ewd,
    input logic eb1, input logic eb2, input logic [2:0] ec, input logic es);
    vec_t v;
    v.pw = pw;   v.pwa = pwa; v.pwd = pwd;
    v.ci = ci;   v.cir = cir;
    v.cv = cv;   v.cwa = cwa; v.cwd = cwd;
    v.a1 = a1;   v.a2 = a2;
    v.ew = ew;   v.ewa = ewa; v.ewd = ewd;
    v.eb1 = eb1; v.eb2 = eb2; v.ec = ec; v.es = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive_idle(input logic [4:0] a1, input logic [4:0] a2);
    pipe_wren = 1'b0; pipe_wa = '0; pipe_wd = '0;
    cp_issue = 1'b0; cp_issue_reg = '0;
    cp_valid = 1'b0; cp_wa = '0; cp_wd = '0;
    ra1 = a1; ra2 = a2;
  endtask

  task automatic check_output();
    vec_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL scoreboard: got empty queue, required a pending vector");
      return;
    end
    e = exp_q.pop_front();
    check("rf_wren", 32'(rf_wren), 32'(e.ew));
    if (e.ew) begin
      check("rf_wa", 32'(rf_wa), 32'(e.ewa));
      check("rf_wd", rf_wd, e.ewd);
    end
    check("busy1", 32'(busy1), 32'(e.eb1));
    check("busy2", 32'(busy2), 32'(e.eb2));
    check("cq_count", 32'(cq_count), 32'(e.ec));
    check("pipe_stall", 32'(pipe_stall), 32'(e.es));
    check("cp_ready", 32'(cp_ready), 32'(e.ec != 3'd4));
`ifdef WB_BYPASS_EN
    check("byp1_hit", 32'(byp1_hit), 32'(e.ew && (e.ewa == e.a1) && (e.a1 != 5'd0)));
    check("byp2_hit", 32'(byp2_hit), 32'(e.ew && (e.ewa == e.a2) && (e.a2 != 5'd0)));
    if (e.ew) begin
      check("byp1_data", byp1_data, e.ewd);
      check("byp2_data", byp2_data, e.ewd);
    end
`endif
  endtask

  task automatic apply_stimulus(input vec_t v);
    pipe_wren = v.pw; pipe_wa = v.pwa; pipe_wd = v.pwd;
    cp_issue = v.ci; cp_issue_reg = v.cir;
    cp_valid = v.cv; cp_wa = v.cwa; cp_wd = v.cwd;
    ra1 = v.a1; ra2 = v.a2;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle(5'd0, 5'd0);

    // Pipeline-only, $0 suppression, scoreboard set/clear, dropped $0 result.
    tbl[0]  = mk(1, 8, 32'hDEADBEEF, 0, 0, 0, 0, 0,       0, 0, 1, 8, 32'hDEADBEEF, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 32'h55,       0, 0, 0, 0, 0,       0, 0, 0, 0, 0,            0, 0, 0, 0);
    tbl[2]  = mk(1, 31, 32'hA5A5A5A5, 0, 0, 0, 0, 0,      0, 0, 1, 31, 32'hA5A5A5A5, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,            0, 0, 0, 0, 0,       0, 0, 0, 0, 0,            0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0,            1, 9, 0, 0, 0,       9, 0, 0, 0, 0,            1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0,            0, 0, 1, 9, 32'h1234, 9, 0, 0, 0, 0,           1, 0, 1, 0);
    tbl[6]  = mk(0, 0, 0,            0, 0, 0, 0, 0,       9, 0, 1, 9, 32'h1234,     0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0,            1, 0, 0, 0, 0,       0, 0, 0, 0, 0,            0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0,            0, 0, 1, 0, 32'h77,  0, 0, 0, 0, 0,            0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0,            0, 0, 0, 0, 0,       0, 0, 0, 0, 0,            0, 0, 0, 0);
    tbl[10] = mk(1, 3, 32'h1,        1, 4, 1, 4, 32'h2,   0, 4, 1, 3, 32'h1,        0, 1, 1, 0);
    tbl[11] = mk(0, 0, 0,            0, 0, 0, 0, 0,       0, 4, 1, 4, 32'h2,        0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("reset rf_wren", 32'(rf_wren), 32'd0);
    check("reset rf_wa", 32'(rf_wa), 32'd0);
    check("reset rf_wd", rf_wd, 32'd0);
    check("reset cq_count", 32'(cq_count), 32'd0);
    check("reset pipe_stall", 32'(pipe_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(tbl[i]);
    end

    $display("[TB] back-pressure and starvation");
    apply_stimulus(mk(1, 10, 32'd100, 0, 0, 1, 11, 32'hB1, 0, 0, 1, 10, 32'd100, 0, 0, 1, 0));
    apply_stimulus(mk(1, 10, 32'd101, 0, 0, 1, 12, 32'hB2, 0, 0, 1, 10, 32'd101, 0, 0, 2, 0));
    apply_stimulus(mk(1, 10, 32'd102, 0, 0, 1, 13, 32'hB3, 0, 0, 1, 10, 32'd102, 0, 0, 3, 0));
    apply_stimulus(mk(1, 10, 32'd103, 0, 0, 1, 14, 32'hB4, 0, 0, 1, 10, 32'd103, 0, 0, 4, 0));
    apply_stimulus(mk(1, 10, 32'd104, 0, 0, 1, 15, 32'hB5, 0, 0, 1, 10, 32'd104, 0, 0, 4, 1));
    apply_stimulus(mk(1, 10, 32'd105, 0, 0, 1, 15, 32'hB5, 0, 0, 1, 11, 32'hB1,  0, 0, 3, 0));
    apply_stimulus(mk(1, 10, 32'd106, 0, 0, 1, 15, 32'hB5, 0, 0, 1, 10, 32'd106, 0, 0, 4, 0));
    apply_stimulus(mk(0, 0, 0,        0, 0, 0, 0, 0,       0, 0, 1, 12, 32'hB2,  0, 0, 3, 0));
    apply_stimulus(mk(0, 0, 0,        0, 0, 0, 0, 0,       0, 0, 1, 13, 32'hB3,  0, 0, 2, 0));
    apply_stimulus(mk(0, 0, 0,        0, 0, 0, 0, 0,       0, 0, 1, 14, 32'hB4,  0, 0, 1, 0));
    apply_stimulus(mk(0, 0, 0,        0, 0, 0, 0, 0,       0, 0, 1, 15, 32'hB5,  0, 0, 0, 0));
    apply_stimulus(mk(0, 0, 0,        0, 0, 0, 0, 0,       0, 0, 0, 0, 0,        0, 0, 0, 0));

    $display("[TB] simultaneous issue and retire on reg 5");
    apply_stimulus(mk(0, 0, 0, 1, 5, 0, 0, 0,       0, 5, 0, 0, 0,       0, 1, 0, 0));
    apply_stimulus(mk(0, 0, 0, 0, 0, 1, 5, 32'h55,  0, 5, 0, 0, 0,       0, 1, 1, 0));
    apply_stimulus(mk(0, 0, 0, 1, 5, 0, 0, 0,       0, 5, 1, 5, 32'h55,  0, 1, 0, 0));
    apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0,       0, 5, 0, 0, 0,       0, 1, 0, 0));
    apply_stimulus(mk(0, 0, 0, 0, 0, 1, 5, 32'h66,  0, 5, 0, 0, 0,       0, 1, 1, 0));
    apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0,       5, 5, 1, 5, 32'h66,  0, 0, 0, 0));

    $display("[TB] reset mid-burst");
    apply_stimulus(mk(0, 0, 0,      1, 20, 0, 0, 0,       20, 21, 0, 0, 0,      1, 0, 0, 0));
    apply_stimulus(mk(0, 0, 0,      1, 21, 0, 0, 0,       20, 21, 0, 0, 0,      1, 1, 0, 0));
    apply_stimulus(mk(1, 1, 32'd11, 0, 0, 1, 20, 32'hC0, 20, 21, 1, 1, 32'd11, 1, 1, 1, 0));
    apply_stimulus(mk(1, 2, 32'd12, 0, 0, 1, 21, 32'hC1, 20, 21, 1, 2, 32'd12, 1, 1, 2, 0));
    apply_stimulus(mk(1, 3, 32'd13, 0, 0, 1, 22, 32'hC2, 20, 21, 1, 3, 32'd13, 1, 1, 3, 0));
    drive_idle(5'd20, 5'd21);
    rst = 1'b1;
    #2;
    check("midreset cq_count", 32'(cq_count), 32'd0);
    check("midreset rf_wren", 32'(rf_wren), 32'd0);
    check("midreset busy1", 32'(busy1), 32'd0);
    check("midreset busy2", 32'(busy2), 32'd0);
    check("midreset pipe_stall", 32'(pipe_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 20, 22, 0, 0, 0, 0, 0, 0, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Owns the single write port of the CPU register file (wren/wa/wd).
- Merges two producers:
  - the fixed-latency pipeline writeback, which is never back-pressured;
  - variable-latency coprocessor results, which use a valid/ready handshake and are buffered in a small FIFO.
- Keeps a busy-bit scoreboard of registers awaiting coprocessor results, so the core can stall on hazards.
- Sits between the writeback stage and the register file.

Parameters:
- W_CPU, 32, data width; matches the shared `W_CPU.
- W_REG, 5, register address width; matches the shared `W_REG.
- CQ_DEPTH, 4, coprocessor result FIFO depth; power of two, at least 2.
- STARVE_MAX, 4, number of consecutive lost arbitrations before the FIFO is given forced priority.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- pipe_wren  in  1  pipeline writeback request
- pipe_wa  in  W_REG  pipeline destination register
- pipe_wd  in  W_CPU  pipeline write data
- pipe_stall  out  1  core must hold pipe_wren low this cycle
- cp_issue  in  1  coprocessor op issued; marks its destination busy
- cp_issue_reg  in  W_REG  destination of the issued op
- cp_valid  in  1  coprocessor result valid
- cp_ready  out  1  FIFO can accept a result
- cp_wa  in  W_REG  result destination
- cp_wd  in  W_CPU  result data
- ra1, ra2  in  W_REG  hazard query addresses (the decode read addresses)
- busy1, busy2  out  1  scoreboard bit for ra1 / ra2
- rf_wren  out  1  register file write enable
- rf_wa  out  W_REG  register file write address
- rf_wd  out  W_CPU  register file write data
- cq_count  out  clog2(CQ_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset:
  - rf_wren, rf_wa, rf_wd, pipe_stall and cq_count are 0.
  - FIFO is emptied, all busy bits are cleared, the starve counter is cleared.
  - A reset mid-operation discards queued results without writing them.
- Output timing:
  - rf_* outputs are registered: a request winning arbitration in cycle N appears on rf_* in cycle N+1.
  - The register file commits it at the next edge.
- FIFO handshake:
  - cp_ready = !full, combinational.
  - A push happens when cp_valid && cp_ready.
  - A result with cp_wa==0 completes the handshake but is dropped and never enqueued.
  - Push and pop in the same cycle are allowed when full: cp_ready stays low when full, so only a pop occurs.
  - Pointers wrap modulo CQ_DEPTH.
- Arbitration, evaluated each cycle:
  - If pipe_stall is high: the FIFO head wins if the FIFO is non-empty; pipe_wren is ignored (core contract).
  - Otherwise, if pipe_wren && pipe_wa!=0: the pipeline wins.
  - Otherwise, if the FIFO is non-empty: the head is popped and wins.
  - Otherwise: rf_wren=0 next cycle.
  - Pipeline writes to $0 are suppressed and treated as no request.
- Starvation guard:
  - The counter increments each cycle the FIFO is non-empty and the pipeline wins.
  - It clears on any pop or when the FIFO is empty.
  - When it reaches STARVE_MAX, pipe_stall is asserted (registered) for exactly one cycle, then the counter clears.
- Scoreboard (32 bits):
  - cp_issue sets busy[cp_issue_reg]; register 0 is never set.
  - A FIFO pop that is written to rf clears busy[head.wa].
  - If set and clear hit the same register in the same cycle, set wins.
  - Issuing to an already-busy register is a core protocol violation (core must stall on busy); the bit stays set.
  - Pipeline writes never change busy bits.
  - busy1/busy2 are combinational from the scoreboard and forced to 0 when the query address is 0.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined, adds outputs byp1_hit/byp2_hit (1 bit) and byp1_data/byp2_data (W_CPU):
  - bypN_hit = rf_wren && rf_wa==raN && raN!=0;
  - byp data = rf_wd;
  - this lets decode forward a value the register file commits at this edge.
- When undefined, these ports are absent and the core relies on stalling.

Decomposition:
- W_CPU, W_REG, register index constants and the FIFO entry struct {wa, wd} go in the shared opcodes/defs include.
- One sub-module, wb_result_fifo: parameterised synchronous FIFO with push/pop/full/empty/count.
- Arbitration, starvation guard and scoreboard stay in the top module.

Test Plan:
- Reset mid-burst:
  - Stimulus: push 3 results, assert rst.
  - Required: cq_count=0, rf_wren=0, busy all 0; no writes after release.
- Pipeline-only:
  - Stimulus: pipe_wren with wa=8, wd=0xDEADBEEF in cycle N.
  - Required: rf_wren=1, rf_wa=8, rf_wd=0xDEADBEEF in cycle N+1.
  - Stimulus: pipe_wa=0.
  - Required: rf_wren stays 0.
- Scoreboard:
  - Stimulus: cp_issue reg 9, ra1=9.
  - Required: busy1=1.
  - Stimulus: result {9, 0x1234} with the pipeline idle.
  - Required: rf write of reg 9 two cycles after the push; busy1 drops the cycle after the pop.
- FIFO full / back-pressure:
  - Stimulus: pipeline writes every cycle, 4 results pushed.
  - Required: cp_ready=0 at cq_count=4; the 5th result is held by the producer and not lost.
- Starvation:
  - Stimulus: continuous pipe_wren with a non-empty FIFO.
  - Required: pipe_stall=1 for one cycle after 4 lost arbitrations; the FIFO head is written that cycle.
- Simultaneous events:
  - Stimulus: cp_issue reg 5 in the same cycle as a pop to reg 5.
  - Required: busy[5] remains 1.
  - Stimulus: with WB_BYPASS_EN, ra2 matches rf_wa.
  - Required: byp2_hit=1 and byp2_data=rf_wd.
